// File: rtl/sfu_sched_pkg.sv
// ----------------------------------------------------------------------------
// sfu_sched_pkg : FP16 operand classes, constants and flop macro for SFU scheduling
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef SFU_SCHED_FF_DEFINED
`define SFU_SCHED_FF_DEFINED
`define SFU_FF(q_, d_, rv_) \
  always_ff @(posedge clk_i or negedge rst_ni) begin \
    if (!rst_ni) q_ <= (rv_); \
    else         q_ <= (d_); \
  end
`endif

package sfu_sched_pkg;

  typedef enum logic [2:0] {
    NORMAL  = 3'd0,
    ZERO    = 3'd1,
    SUBNORM = 3'd2,
    INF     = 3'd3,
    NAN     = 3'd4
  } fp16_class_e;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

  function automatic fp16_class_e fp16_classify(input logic [15:0] x);
    fp16_class_e c;
    c = NORMAL;
    if (x[14:10] == 5'h00)      c = (x[9:0] == 10'h0) ? ZERO : SUBNORM;
    else if (x[14:10] == 5'h1F) c = (x[9:0] == 10'h0) ? INF  : NAN;
    return c;
  endfunction

  // Reciprocal of a non-normal operand; subnormals flush to signed infinity.
  function automatic logic [15:0] fp16_special_result(input fp16_class_e c, input logic s);
    logic [15:0] r;
    case (c)
      ZERO, SUBNORM: r = {s, 5'h1F, 10'h000};
      INF:           r = {s, 15'h0000};
      default:       r = FP16_QNAN;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : round-robin arbiter, search starts at rr_q, pointer moves past winner
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import sfu_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W:0]   cand;
  logic [ID_W:0]   nxt;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (en_i && !valid_o && req_i[cand[ID_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[ID_W-1:0];
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

  always_comb begin
    nxt = {1'b0, idx_o} + (ID_W+1)'(1);
    if (nxt >= (ID_W+1)'(NUM_REQ)) nxt = '0;
    rr_d = valid_o ? nxt[ID_W-1:0] : rr_q;
  end

  `SFU_FF(rr_q, rr_d, '0)

endmodule

`default_nettype wire

// File: rtl/fp16_recip_sched.sv
// ----------------------------------------------------------------------------
// fp16_recip_sched : shares one FP16 reciprocal datapath among NUM_REQ requesters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp16_recip_sched
  import sfu_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TAG_W   = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0][15:0]       req_operand_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag_i,
  output logic [15:0]                    dp_operand_o,
  input  logic [15:0]                    dp_result_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [15:0]                    rsp_result_o,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic [TAG_W-1:0]               rsp_tag_o,
  output logic                           rsp_special_o,
  output logic                           busy_o
);

  logic              s1_valid_q, s1_valid_d;
  logic [15:0]       s1_op_q, s1_op_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  fp16_class_e       s1_cls_q, s1_cls_d;

  logic              s2_valid_q, s2_valid_d;
  logic [15:0]       s2_res_q, s2_res_d;
  logic [ID_W-1:0]   s2_id_q, s2_id_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
  logic              s2_spec_q, s2_spec_d;

  logic              s2_load;
  logic              s1_en;
  logic              arb_valid;
  logic [ID_W-1:0]   arb_idx;

  assign s2_load = !s2_valid_q || rsp_ready_i;
  assign s1_en   = !s1_valid_q || s2_load;

  // Reset gates the grant so ready reads zero while rst_ni is held low.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_valid_i),
    .en_i    (rst_ni && s1_en),
    .gnt_o   (req_ready_o),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_id_d    = s1_id_q;
    s1_tag_d   = s1_tag_q;
    s1_cls_d   = s1_cls_q;
    if (s1_en) begin
      s1_valid_d = arb_valid;
      if (arb_valid) begin
        s1_op_d  = req_operand_i[arb_idx];
        s1_id_d  = arb_idx;
        s1_tag_d = req_tag_i[arb_idx];
        s1_cls_d = fp16_classify(req_operand_i[arb_idx]);
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_id_d    = s2_id_q;
    s2_tag_d   = s2_tag_q;
    s2_spec_d  = s2_spec_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d  = (s1_cls_q == NORMAL) ? dp_result_i
                                         : fp16_special_result(s1_cls_q, s1_op_q[15]);
        s2_id_d   = s1_id_q;
        s2_tag_d  = s1_tag_q;
        s2_spec_d = (s1_cls_q != NORMAL);
      end
    end
  end

  `SFU_FF(s1_valid_q, s1_valid_d, 1'b0)
  `SFU_FF(s1_op_q,    s1_op_d,    16'h0000)
  `SFU_FF(s1_id_q,    s1_id_d,    '0)
  `SFU_FF(s1_tag_q,   s1_tag_d,   '0)
  `SFU_FF(s1_cls_q,   s1_cls_d,   NORMAL)
  `SFU_FF(s2_valid_q, s2_valid_d, 1'b0)
  `SFU_FF(s2_res_q,   s2_res_d,   16'h0000)
  `SFU_FF(s2_id_q,    s2_id_d,    '0)
  `SFU_FF(s2_tag_q,   s2_tag_d,   '0)
  `SFU_FF(s2_spec_q,  s2_spec_d,  1'b0)

  assign dp_operand_o  = s1_valid_q ? s1_op_q : FP16_ONE;
  assign rsp_valid_o   = s2_valid_q;
  assign rsp_result_o  = s2_res_q;
  assign rsp_id_o      = s2_id_q;
  assign rsp_tag_o     = s2_tag_q;
  assign rsp_special_o = s2_spec_q;
  assign busy_o        = s1_valid_q | s2_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fp16_recip_sched.sv
// ----------------------------------------------------------------------------
// tb_fp16_recip_sched : scoreboard bench for the FP16 reciprocal scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fp16_recip_sched;

  localparam int NR = 4;
  localparam int TW = 4;

  logic                  clk_i;
  logic                  rst_ni;
  logic [NR-1:0]         req_valid_i;
  logic [NR-1:0]         req_ready_o;
  logic [NR-1:0][15:0]   req_operand_i;
  logic [NR-1:0][TW-1:0] req_tag_i;
  logic [15:0]           dp_operand_o;
  logic [15:0]           dp_result_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [15:0]           rsp_result_o;
  logic [1:0]            rsp_id_o;
  logic [TW-1:0]         rsp_tag_o;
  logic                  rsp_special_o;
  logic                  busy_o;

  fp16_recip_sched #(.NUM_REQ(NR), .TAG_W(TW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_operand_i (req_operand_i),
    .req_tag_i     (req_tag_i),
    .dp_operand_o  (dp_operand_o),
    .dp_result_i   (dp_result_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_result_o  (rsp_result_o),
    .rsp_id_o      (rsp_id_o),
    .rsp_tag_o     (rsp_tag_o),
    .rsp_special_o (rsp_special_o),
    .busy_o        (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]    id;
    logic [TW-1:0] tag;
    logic [15:0]   res;
    logic          sp;
  } exp_t;

  exp_t         sb[$];
  logic [15:0]  opq[NR][$];
  logic [TW-1:0] tagc[NR];
  int           vectors = 0;
  int           miscompares = 0;
  int           rdy_mode = 0;
  int           m_rr = 0;
  bit           m_s1 = 0, m_s2 = 0;
  logic [15:0]  m_s1_op = 16'h0;

  // Stand-in datapath: exact for powers of two (1/2 -> 0.5 is 4000 -> 3800).
  function automatic logic [15:0] model_recip(input logic [15:0] x);
    logic [4:0] e;
    e = 5'd30 - x[14:10];
    return {x[15], e, (x[9:0] == 10'h0) ? 10'h0 : ~x[9:0]};
  endfunction

  assign dp_result_i = model_recip(dp_operand_o);

  function automatic exp_t expect_of(input int id, input logic [TW-1:0] tag, input logic [15:0] op);
    exp_t r;
    r.id  = 2'(id);
    r.tag = tag;
    r.sp  = 1'b1;
    if (op[14:10] == 5'h00)      r.res = {op[15], 5'h1F, 10'h0};
    else if (op[14:10] == 5'h1F) r.res = (op[9:0] == 10'h0) ? {op[15], 15'h0} : 16'h7E00;
    else begin
      r.res = model_recip(op);
      r.sp  = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [NR-1:0] v, eg;
    int win, idx;
    bit can, load, adv;
    @(negedge clk_i);
    for (int i = 0; i < NR; i++) begin
      v[i] = (opq[i].size() > 0);
      req_operand_i[i] = v[i] ? opq[i][0] : 16'h0;
      req_tag_i[i] = tagc[i];
    end
    req_valid_i = v;
    case (rdy_mode)
      0:       rsp_ready_i = 1'b1;
      1:       rsp_ready_i = 1'b0;
      default: rsp_ready_i = 1'($urandom_range(0, 1));
    endcase
    #1;
    can = !m_s1 || !m_s2 || rsp_ready_i;
    eg  = '0;
    win = -1;
    if (can) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr + k) % NR;
        if (win < 0 && v[idx]) win = idx;
      end
    end
    if (win >= 0) eg[win] = 1'b1;
    check("req_ready", 32'(req_ready_o), 32'(eg));
    check("rsp_valid", 32'(rsp_valid_o), 32'(m_s2));
    check("busy", 32'(busy_o), 32'(m_s1 | m_s2));
    check("dp_operand", 32'(dp_operand_o), m_s1 ? 32'(m_s1_op) : 32'h3C00);
    if (rsp_valid_o) begin
      if (sb.size() == 0) check("rsp_spurious", 32'(rsp_valid_o), 32'h0);
      else begin
        check("rsp_id", 32'(rsp_id_o), 32'(sb[0].id));
        check("rsp_tag", 32'(rsp_tag_o), 32'(sb[0].tag));
        check("rsp_result", 32'(rsp_result_o), 32'(sb[0].res));
        check("rsp_special", 32'(rsp_special_o), 32'(sb[0].sp));
        if (rsp_ready_i) void'(sb.pop_front());
      end
    end
    if (win >= 0) sb.push_back(expect_of(win, tagc[win], opq[win][0]));
    load = !m_s2 || rsp_ready_i;
    adv  = load || !m_s1;
    if (load) m_s2 = m_s1;
    if (adv) begin
      m_s1 = (win >= 0);
      if (win >= 0) m_s1_op = opq[win][0];
    end
    if (win >= 0) m_rr = (win + 1) % NR;
    @(posedge clk_i);
    #1;
    if (win >= 0) begin
      void'(opq[win].pop_front());
      tagc[win] = tagc[win] + 1'b1;
    end
  endtask

  function automatic int pending();
    int n;
    n = sb.size() + int'(m_s1) + int'(m_s2);
    for (int i = 0; i < NR; i++) n += opq[i].size();
    return n;
  endfunction

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      step();
      n++;
    end
    if (pending() > 0) check("drain_timeout", 32'(pending()), 32'h0);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0: r[14:0] = 15'h0;
      1: r[14:10] = 5'h00;
      2: r[14:0] = 15'h7C00;
      3: r[14:10] = 5'h1F;
      default: r[14:10] = 5'($urandom_range(1, 30));
    endcase
    return r;
  endfunction

  initial begin
    rst_ni        = 1'b0;
    req_valid_i   = '1;
    req_operand_i = '0;
    req_tag_i     = '0;
    rsp_ready_i   = 1'b0;
    for (int i = 0; i < NR; i++) tagc[i] = '0;
    #2;
    check("rst_req_ready", 32'(req_ready_o), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("rst_rsp_result", 32'(rsp_result_o), 32'h0);
    check("rst_rsp_id", 32'(rsp_id_o), 32'h0);
    check("rst_rsp_tag", 32'(rsp_tag_o), 32'h0);
    check("rst_rsp_special", 32'(rsp_special_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_dp_operand", 32'(dp_operand_o), 32'h3C00);
    req_valid_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fairness: all requesters streaming, pointer starts at 0.
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 8; j++) opq[i].push_back({1'b0, 5'($urandom_range(1, 30)), 10'($urandom)});
    run_drain(100);

    // Single request from requester 2.
    tagc[2] = 4'd5;
    opq[2].push_back(16'h4000);
    run_drain(20);

    // Pointer wrap: lone grant to 3 moves the pointer to 0.
    opq[3].push_back(16'h3C00);
    run_drain(20);
    opq[0].push_back(16'h4400);
    opq[3].push_back(16'h4800);
    run_drain(20);

    // Backpressure for five cycles with work pending.
    for (int j = 0; j < 3; j++) begin
      opq[1].push_back({1'b1, 5'd17, 10'($urandom)});
      opq[2].push_back({1'b0, 5'd12, 10'($urandom)});
    end
    rdy_mode = 1;
    repeat (5) step();
    rdy_mode = 0;
    run_drain(40);

    // IEEE specials mixed with normal traffic.
    opq[0].push_back(16'h8000);
    opq[0].push_back(16'h0001);
    opq[0].push_back(16'h7C00);
    opq[0].push_back(16'h7D00);
    opq[3].push_back(16'h3555);
    opq[3].push_back(16'hC123);
    run_drain(40);

    // Random operands with random response backpressure.
    rdy_mode = 2;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 12; j++) opq[i].push_back(rand_op());
    run_drain(600);
    rdy_mode = 0;

    // Asynchronous reset in the middle of a stream.
    for (int j = 0; j < 6; j++) opq[2].push_back(16'h4000 + 16'(j));
    repeat (3) step();
    #2;
    rst_ni = 1'b0;
    #1;
    check("mrst_req_ready", 32'(req_ready_o), 32'h0);
    check("mrst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("mrst_rsp_result", 32'(rsp_result_o), 32'h0);
    check("mrst_rsp_special", 32'(rsp_special_o), 32'h0);
    check("mrst_busy", 32'(busy_o), 32'h0);
    check("mrst_dp_operand", 32'(dp_operand_o), 32'h3C00);
    req_valid_i = '0;
    sb.delete();
    for (int i = 0; i < NR; i++) opq[i].delete();
    m_s1 = 0;
    m_s2 = 0;
    m_rr = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    opq[1].push_back(16'h4200);
    opq[3].push_back(16'h4600);
    opq[0].push_back(16'h4A00);
    run_drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
